// File: rtl/regfile_pkg.sv
// Shared register-file definitions: bus widths, register count and address helpers.
package regfile_pkg;

    localparam int unsigned REG_W      = 32;  // RegBus width
    localparam int unsigned REG_ADDR_W = 5;   // RegAddrBus width
    localparam int unsigned REG_NUM    = 32;  // architectural registers

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    typedef logic [REG_W-1:0]      reg_bus_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_bus_t  ZERO_WORD    = '0;
    localparam reg_addr_t NOP_REG_ADDR = '0;

    // x0 is hardwired to zero, so any access to it is a no-op.
    function automatic logic is_x0(input reg_addr_t addr);
        return addr == NOP_REG_ADDR;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: enable / x0 / write-back bypass / busy priority mux.
module regfile_read_port
    import regfile_pkg::*;
(
    input  logic      enable_i,
    input  reg_addr_t addr_i,
    input  logic      w_enable_i,
    input  reg_addr_t w_addr_i,
    input  reg_bus_t  w_data_i,
    input  reg_bus_t  reg_data_i,
    input  logic      reg_pending_i,
    output reg_bus_t  data_o,
    output logic      busy_o
);

    // Priority: disabled, x0, same-cycle write-back, stored value.
    always_comb begin
        data_o = ZERO_WORD;
        busy_o = 1'b0;
        if (!enable_i || is_x0(addr_i)) begin
            data_o = ZERO_WORD;
            busy_o = 1'b0;
        end else if ((w_enable_i == WRITE_ENABLE) && (w_addr_i == addr_i)) begin
            // The producer is retiring right now, so the operand is ready.
            data_o = w_data_i;
            busy_o = 1'b0;
        end else begin
            data_o = reg_data_i;
            busy_o = reg_pending_i;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with per-register pending-write scoreboard and bypassed reads.
module regfile_sb
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r1_enable_i,
    input  reg_addr_t             r1_addr_i,
    output reg_bus_t              r1_data_o,
    output logic                  r1_busy_o,
    input  logic                  r2_enable_i,
    input  reg_addr_t             r2_addr_i,
    output reg_bus_t              r2_data_o,
    output logic                  r2_busy_o,
    input  logic                  iss_enable_i,
    input  reg_addr_t             iss_addr_i,
    input  logic                  w_enable_i,
    input  reg_addr_t             w_addr_i,
    input  reg_bus_t              w_data_i,
    input  logic                  flush_i,
    output logic [REG_ADDR_W:0]   pending_cnt_o
);

    localparam int unsigned CNT_W = REG_ADDR_W + 1;

    reg_bus_t               mem_q [REG_NUM];
    reg_bus_t               mem_d [REG_NUM];
    logic [REG_NUM-1:0]     pending_q;
    logic [REG_NUM-1:0]     pending_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;

    // Register write; x0 is never written.
    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            mem_d[i] = mem_q[i];
        end
        if ((w_enable_i == WRITE_ENABLE) && !is_x0(w_addr_i)) begin
            mem_d[w_addr_i] = w_data_i;
        end
    end

    // Scoreboard: flush beats everything, then write-back clears, then issue sets.
    always_comb begin
        pending_d = pending_q;
        if (flush_i) begin
            pending_d = '0;
        end else begin
            if ((w_enable_i == WRITE_ENABLE) && !is_x0(w_addr_i)) begin
                pending_d[w_addr_i] = 1'b0;
            end
            // A newer producer issued this cycle stays outstanding.
            if (iss_enable_i && !is_x0(iss_addr_i)) begin
                pending_d[iss_addr_i] = 1'b1;
            end
        end
    end

    // Popcount of next-state bits so the counter tracks the bits on the same edge.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            cnt_d = cnt_d + CNT_W'(pending_d[i]);
        end
    end

    // State registers; reset discards all writes and pending state at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                mem_q[i] <= ZERO_WORD;
            end
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                mem_q[i] <= mem_d[i];
            end
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending_cnt_o = cnt_q;

    regfile_read_port u_read_port_1 (
        .enable_i      (r1_enable_i),
        .addr_i        (r1_addr_i),
        .w_enable_i    (w_enable_i),
        .w_addr_i      (w_addr_i),
        .w_data_i      (w_data_i),
        .reg_data_i    (mem_q[r1_addr_i]),
        .reg_pending_i (pending_q[r1_addr_i]),
        .data_o        (r1_data_o),
        .busy_o        (r1_busy_o)
    );

    regfile_read_port u_read_port_2 (
        .enable_i      (r2_enable_i),
        .addr_i        (r2_addr_i),
        .w_enable_i    (w_enable_i),
        .w_addr_i      (w_addr_i),
        .w_data_i      (w_data_i),
        .reg_data_i    (mem_q[r2_addr_i]),
        .reg_pending_i (pending_q[r2_addr_i]),
        .data_o        (r2_data_o),
        .busy_o        (r2_busy_o)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb.
module tb_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic        r1_enable_i;
    logic [4:0]  r1_addr_i;
    logic [31:0] r1_data_o;
    logic        r1_busy_o;
    logic        r2_enable_i;
    logic [4:0]  r2_addr_i;
    logic [31:0] r2_data_o;
    logic        r2_busy_o;
    logic        iss_enable_i;
    logic [4:0]  iss_addr_i;
    logic        w_enable_i;
    logic [4:0]  w_addr_i;
    logic [31:0] w_data_i;
    logic        flush_i;
    logic [5:0]  pending_cnt_o;

    int total;
    int bad;

    regfile_sb dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .r1_enable_i   (r1_enable_i),
        .r1_addr_i     (r1_addr_i),
        .r1_data_o     (r1_data_o),
        .r1_busy_o     (r1_busy_o),
        .r2_enable_i   (r2_enable_i),
        .r2_addr_i     (r2_addr_i),
        .r2_data_o     (r2_data_o),
        .r2_busy_o     (r2_busy_o),
        .iss_enable_i  (iss_enable_i),
        .iss_addr_i    (iss_addr_i),
        .w_enable_i    (w_enable_i),
        .w_addr_i      (w_addr_i),
        .w_data_i      (w_data_i),
        .flush_i       (flush_i),
        .pending_cnt_o (pending_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drop all request inputs.
    task automatic idle();
        r1_enable_i  = 1'b0;
        r1_addr_i    = '0;
        r2_enable_i  = 1'b0;
        r2_addr_i    = '0;
        iss_enable_i = 1'b0;
        iss_addr_i   = '0;
        w_enable_i   = 1'b0;
        w_addr_i     = '0;
        w_data_i     = '0;
        flush_i      = 1'b0;
    endtask

    // Inputs change on the falling edge; one rising edge passes; back on a falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        r1_enable_i = 1'b1;
        r1_addr_i   = 5'd5;
        #1;
        total++;
        if (pending_cnt_o !== 6'd0) begin
            bad++;
            $display("FAIL reset_cnt got=%0d want=0", pending_cnt_o);
        end
        total++;
        if (r1_data_o !== 32'h0 || r1_busy_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_read got=%h/%b want=0/0", r1_data_o, r1_busy_o);
        end
        rst_n = 1'b1;
        idle();
        @(negedge clk);
    endtask

    task automatic test_write_read();
        w_enable_i = 1'b1;
        w_addr_i   = 5'd5;
        w_data_i   = 32'hDEADBEEF;
        step();
        idle();
        r1_enable_i = 1'b1;
        r1_addr_i   = 5'd5;
        r2_enable_i = 1'b1;
        r2_addr_i   = 5'd0;
        #1;
        total++;
        if (r1_data_o !== 32'hDEADBEEF || r1_busy_o !== 1'b0) begin
            bad++;
            $display("FAIL wr_r1 got=%h/%b want=deadbeef/0", r1_data_o, r1_busy_o);
        end
        total++;
        if (r2_data_o !== 32'h0 || r2_busy_o !== 1'b0) begin
            bad++;
            $display("FAIL wr_r2_x0 got=%h/%b want=0/0", r2_data_o, r2_busy_o);
        end
        idle();
    endtask

    task automatic test_x0();
        w_enable_i = 1'b1;
        w_addr_i   = 5'd0;
        w_data_i   = 32'h1234;
        step();
        idle();
        r1_enable_i = 1'b1;
        r1_addr_i   = 5'd0;
        #1;
        total++;
        if (r1_data_o !== 32'h0) begin
            bad++;
            $display("FAIL x0_read got=%h want=0", r1_data_o);
        end
        iss_enable_i = 1'b1;
        iss_addr_i   = 5'd0;
        step();
        idle();
        #1;
        total++;
        if (pending_cnt_o !== 6'd0) begin
            bad++;
            $display("FAIL x0_issue_cnt got=%0d want=0", pending_cnt_o);
        end
    endtask

    task automatic test_bypass();
        w_enable_i = 1'b1;
        w_addr_i   = 5'd7;
        w_data_i   = 32'h1;
        step();
        w_data_i    = 32'hA5A5A5A5;
        r1_enable_i = 1'b1;
        r1_addr_i   = 5'd7;
        #1;
        total++;
        if (r1_data_o !== 32'hA5A5A5A5 || r1_busy_o !== 1'b0) begin
            bad++;
            $display("FAIL bypass got=%h/%b want=a5a5a5a5/0", r1_data_o, r1_busy_o);
        end
        r1_enable_i = 1'b0;
        #1;
        total++;
        if (r1_data_o !== 32'h0) begin
            bad++;
            $display("FAIL bypass_disabled got=%h want=0", r1_data_o);
        end
        step();
        idle();
        r2_enable_i = 1'b1;
        r2_addr_i   = 5'd7;
        #1;
        total++;
        if (r2_data_o !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL bypass_stored got=%h want=a5a5a5a5", r2_data_o);
        end
        idle();
    endtask

    task automatic test_scoreboard();
        iss_enable_i = 1'b1;
        iss_addr_i   = 5'd3;
        step();
        idle();
        r2_enable_i = 1'b1;
        r2_addr_i   = 5'd3;
        #1;
        total++;
        if (r2_busy_o !== 1'b1 || pending_cnt_o !== 6'd1) begin
            bad++;
            $display("FAIL sb_issue got=%b/%0d want=1/1", r2_busy_o, pending_cnt_o);
        end
        w_enable_i = 1'b1;
        w_addr_i   = 5'd3;
        w_data_i   = 32'h42;
        #1;
        total++;
        if (r2_data_o !== 32'h42 || r2_busy_o !== 1'b0) begin
            bad++;
            $display("FAIL sb_wb_bypass got=%h/%b want=42/0", r2_data_o, r2_busy_o);
        end
        step();
        w_enable_i = 1'b0;
        #1;
        total++;
        if (r2_data_o !== 32'h42 || r2_busy_o !== 1'b0 || pending_cnt_o !== 6'd0) begin
            bad++;
            $display("FAIL sb_retired got=%h/%b/%0d want=42/0/0", r2_data_o, r2_busy_o,
                     pending_cnt_o);
        end
        idle();
    endtask

    task automatic test_same_cycle();
        iss_enable_i = 1'b1;
        iss_addr_i   = 5'd9;
        w_enable_i   = 1'b1;
        w_addr_i     = 5'd9;
        w_data_i     = 32'h99;
        step();
        idle();
        r1_enable_i = 1'b1;
        r1_addr_i   = 5'd9;
        #1;
        total++;
        if (r1_busy_o !== 1'b1 || r1_data_o !== 32'h99 || pending_cnt_o !== 6'd1) begin
            bad++;
            $display("FAIL set_wins got=%b/%h/%0d want=1/99/1", r1_busy_o, r1_data_o,
                     pending_cnt_o);
        end
        // Re-issue of a pending register and write-back of an idle one change nothing.
        iss_enable_i = 1'b1;
        iss_addr_i   = 5'd9;
        w_enable_i   = 1'b1;
        w_addr_i     = 5'd12;
        w_data_i     = 32'hC;
        step();
        idle();
        #1;
        total++;
        if (pending_cnt_o !== 6'd1) begin
            bad++;
            $display("FAIL reissue_cnt got=%0d want=1", pending_cnt_o);
        end
        iss_enable_i = 1'b1;
        iss_addr_i   = 5'd1;
        step();
        iss_addr_i = 5'd2;
        step();
        iss_addr_i = 5'd4;
        step();
        idle();
        #1;
        total++;
        if (pending_cnt_o !== 6'd4) begin
            bad++;
            $display("FAIL multi_issue_cnt got=%0d want=4", pending_cnt_o);
        end
        flush_i      = 1'b1;
        iss_enable_i = 1'b1;
        iss_addr_i   = 5'd6;
        step();
        idle();
        r1_enable_i = 1'b1;
        r1_addr_i   = 5'd6;
        r2_enable_i = 1'b1;
        r2_addr_i   = 5'd9;
        #1;
        total++;
        if (pending_cnt_o !== 6'd0 || r1_busy_o !== 1'b0 || r2_busy_o !== 1'b0) begin
            bad++;
            $display("FAIL flush got=%0d/%b/%b want=0/0/0", pending_cnt_o, r1_busy_o,
                     r2_busy_o);
        end
        idle();
    endtask

    task automatic test_async_reset();
        iss_enable_i = 1'b1;
        iss_addr_i   = 5'd10;
        step();
        idle();
        r1_enable_i = 1'b1;
        r1_addr_i   = 5'd10;
        r2_enable_i = 1'b1;
        r2_addr_i   = 5'd5;
        #1;
        total++;
        if (pending_cnt_o !== 6'd1 || r1_busy_o !== 1'b1 || r2_data_o !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL pre_reset got=%0d/%b/%h want=1/1/deadbeef", pending_cnt_o,
                     r1_busy_o, r2_data_o);
        end
        // Assert reset away from any rising edge.
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (pending_cnt_o !== 6'd0 || r1_busy_o !== 1'b0) begin
            bad++;
            $display("FAIL async_rst_sb got=%0d/%b want=0/0", pending_cnt_o, r1_busy_o);
        end
        total++;
        if (r2_data_o !== 32'h0) begin
            bad++;
            $display("FAIL async_rst_reg got=%h want=0", r2_data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_x0();
        test_bypass();
        test_scoreboard();
        test_same_cycle();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
